// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between the I-cache (port 0) and D-cache (port 1).
// Build option ARB_RR_EN: round-robin tie-break replaces fixed priority and the starvation guard.
module mem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int LINE_W     = 128,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [WIDTH-1:0]  addr0,
  input  logic [LINE_W-1:0] wdata0,
  output logic [LINE_W-1:0] rdata0,
  output logic              ready0,
  input  logic              req1,
  input  logic              we1,
  input  logic [WIDTH-1:0]  addr1,
  input  logic [LINE_W-1:0] wdata1,
  output logic [LINE_W-1:0] rdata1,
  output logic              ready1,
  output logic              mem_req,
  output logic              WriteEnable,
  output logic [WIDTH-1:0]  memory_address,
  output logic [LINE_W-1:0] mem_writedata,
  input  logic [LINE_W-1:0] mem_readdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);

  // state | meaning
  // IDLE  | no owner; arbitrate on req0/req1 and register the winner
  // GNT0  | port 0 owns the memory port until mem_ready or req0 drops
  // GNT1  | port 1 owns the memory port until mem_ready or req1 drops
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t state_q, state_d;
  logic   lock_valid_q, lock_valid_d;
  logic   lock_port_q, lock_port_d;
  logic   winner;

`ifdef ARB_RR_EN
  logic last_port_q, last_port_d;
`else
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
`endif

  // A write-back locks its port so the following line fill cannot be split off.
  always_comb begin
    winner = req1;
    if (lock_valid_q && (lock_port_q ? req1 : req0)) begin
      winner = lock_port_q;
    end else if (req0 && req1) begin
`ifdef ARB_RR_EN
      winner = ~last_port_q;
`else
      winner = (starve_cnt_q == SW'(STARVE_MAX)) ? 1'b0 : 1'b1;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_valid_d = lock_valid_q;
    lock_port_d  = lock_port_q;
`ifdef ARB_RR_EN
    last_port_d  = last_port_q;
`else
    starve_cnt_d = starve_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d      = winner ? GNT1 : GNT0;
          lock_valid_d = 1'b0;
`ifdef ARB_RR_EN
          last_port_d  = winner;
`else
          if (!winner) begin
            starve_cnt_d = '0;
          end else if (req0 && (starve_cnt_q != SW'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
          end
`endif
        end
      end
      GNT0: begin
        if (mem_ready) begin
          state_d = IDLE;
          if (we0) begin
            lock_valid_d = 1'b1;
            lock_port_d  = 1'b0;
          end
        end else if (!req0) begin
          state_d = IDLE;
        end
      end
      GNT1: begin
        if (mem_ready) begin
          state_d = IDLE;
          if (we1) begin
            lock_valid_d = 1'b1;
            lock_port_d  = 1'b1;
          end
        end else if (!req1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lock_valid_q <= 1'b0;
      lock_port_q  <= 1'b0;
`ifdef ARB_RR_EN
      last_port_q  <= 1'b1;
`else
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lock_valid_q <= lock_valid_d;
      lock_port_q  <= lock_port_d;
`ifdef ARB_RR_EN
      last_port_q  <= last_port_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  always_comb begin
    mem_req        = 1'b0;
    WriteEnable    = 1'b0;
    memory_address = '0;
    mem_writedata  = '0;
    grant          = 2'b00;
    rdata0         = '0;
    rdata1         = '0;
    ready0         = 1'b0;
    ready1         = 1'b0;
    unique case (state_q)
      GNT0: begin
        mem_req        = req0;
        WriteEnable    = we0;
        memory_address = addr0;
        mem_writedata  = wdata0;
        grant          = 2'b01;
        rdata0         = mem_readdata;
        ready0         = mem_ready;
      end
      GNT1: begin
        mem_req        = req1;
        WriteEnable    = we1;
        memory_address = addr1;
        mem_writedata  = wdata1;
        grant          = 2'b10;
        rdata1         = mem_readdata;
        ready1         = mem_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a transaction-level arbitration model,
// a behavioural memory, directed scenarios and randomized two-port traffic.
module tb_mem_arbiter;
  localparam int WIDTH      = 32;
  localparam int LINE_W     = 128;
  localparam int STARVE_MAX = 8;
`ifdef ARB_RR_EN
  localparam logic [1:0] TIE_FIRST = 2'b01;
`else
  localparam logic [1:0] TIE_FIRST = 2'b10;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, we0, req1, we1;
  logic [WIDTH-1:0]  addr0, addr1;
  logic [LINE_W-1:0] wdata0, wdata1, rdata0, rdata1;
  logic              ready0, ready1;
  logic              mem_req, WriteEnable, mem_ready;
  logic [WIDTH-1:0]  memory_address;
  logic [LINE_W-1:0] mem_writedata, mem_readdata;
  logic [1:0]        grant;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(WIDTH), .LINE_W(LINE_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ready0(ready0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ready1(ready1),
    .mem_req(mem_req), .WriteEnable(WriteEnable), .memory_address(memory_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_ready(mem_ready),
    .grant(grant)
  );

  typedef struct {
    bit                we;
    logic [LINE_W-1:0] data;
  } exp_t;

  exp_t              exp_q0[$];
  exp_t              exp_q1[$];
  int                gnt_q[$];
  logic [1:0]        gnt_log[$];
  logic [LINE_W-1:0] mem_arr[logic [WIDTH-1:0]];
  logic [LINE_W-1:0] ref_mem[logic [WIDTH-1:0]];
  int                errors = 0;
  int                checks = 0;
  bit                mon_en = 1'b0;
  int                mem_lat = 3;
  bit                mem_rand = 1'b0;

  function automatic logic [LINE_W-1:0] init_pat(input logic [WIDTH-1:0] a);
    return {a ^ 32'h5A5A_0000, ~a, a + 32'h1111_1111, a};
  endfunction

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic seed(input logic [WIDTH-1:0] a, input logic [LINE_W-1:0] d);
    mem_arr[a] = d;
    ref_mem[a] = d;
  endtask

  // Expected response for one transaction, from the reference view of memory contents.
  task automatic push_exp(input int p, input bit w, input logic [WIDTH-1:0] a, input logic [LINE_W-1:0] d);
    exp_t e;
    e.we   = w;
    e.data = ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
    if (w) ref_mem[a] = d;
    if (p == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic drop(input int p);
    if (p == 0) begin req0 = 1'b0; we0 = 1'b0; end
    else        begin req1 = 1'b0; we1 = 1'b0; end
  endtask

  task automatic wait_ready(input int p);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      seen = (p == 0) ? ready0 : ready1;
    end
    if (!seen) fail_now($sformatf("timeout_ready%0d", p));
  endtask

  // Issue at posedge+1; returns at posedge+1 of the cycle after completion.
  task automatic do_txn(input int p, input bit w, input logic [WIDTH-1:0] a,
                        input logic [LINE_W-1:0] d, input bit keep);
    push_exp(p, w, a, d);
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    wait_ready(p);
    @(posedge clk); #1;
    if (!keep) drop(p);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    drop(0);
    drop(1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_log(input string name, input logic [1:0] ex[$]);
    check({name, "_count"}, gnt_log.size(), ex.size());
    for (int i = 0; i < ex.size() && i < gnt_log.size(); i++) check(name, gnt_log[i], ex[i]);
  endtask

  task automatic rand_port(input int p);
    logic [WIDTH-1:0] base = (p == 0) ? 32'h0000_8000 : 32'h0001_8000;
    for (int i = 0; i < 50; i++) begin
      bit               w = 1'($urandom_range(0, 1));
      logic [WIDTH-1:0] a = base + 32'($urandom_range(0, 7)) * 32'h10;
      logic [LINE_W-1:0] d = {$urandom, $urandom, $urandom, $urandom};
      bit               keep = ($urandom_range(0, 2) != 0) && (i < 49);
      do_txn(p, w, a, d, keep);
      if (!keep) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  // Behavioural memory: answers mem_req after a latency, holds contents in an associative array.
  initial begin
    int cnt = 0;
    int cur_lat = 0;
    forever begin
      @(posedge clk); #2;
      if (mem_ready) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (mem_req) begin
        if (cnt == 0) cur_lat = mem_rand ? $urandom_range(1, 4) : mem_lat;
        cnt++;
        if (cnt > cur_lat) begin
          mem_ready = 1'b1;
          cnt = 0;
          if (WriteEnable) mem_arr[memory_address] = mem_writedata;
          else mem_readdata = mem_arr.exists(memory_address) ? mem_arr[memory_address] : init_pat(memory_address);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: output mux checks, scoreboard pops, and the transaction-level arbitration model.
  int         m_owner = -1;
  bit         m_lock_v = 1'b0;
  int         m_lock_p = 0;
  int         m_starve = 0;
  int         m_last = 1;
  int         m_w;
  logic [1:0] prev_grant = 2'b00;
  exp_t       e_m;

  always @(negedge clk) begin
    if (mon_en) begin
      case (grant)
        2'b01: begin
          check("mux_ctrl", {mem_req, WriteEnable, ready0, ready1}, {req0, we0, mem_ready, 1'b0});
          check("mux_addr", memory_address, addr0);
          check("mux_wdata", mem_writedata, wdata0);
          check("mux_rdata", {rdata0, rdata1}, {mem_readdata, 128'h0});
        end
        2'b10: begin
          check("mux_ctrl", {mem_req, WriteEnable, ready0, ready1}, {req1, we1, 1'b0, mem_ready});
          check("mux_addr", memory_address, addr1);
          check("mux_wdata", mem_writedata, wdata1);
          check("mux_rdata", {rdata0, rdata1}, {128'h0, mem_readdata});
        end
        default: begin
          check("idle_grant", grant, 2'b00);
          check("idle_ctrl", {mem_req, WriteEnable, ready0, ready1}, 4'b0000);
          check("idle_addr", memory_address, 0);
          check("idle_data", {mem_writedata, rdata0, rdata1}, 0);
        end
      endcase
      if (ready0) begin
        if (exp_q0.size() == 0) fail_now("ready0_unexpected");
        else begin
          e_m = exp_q0.pop_front();
          if (!e_m.we) check("rdata0", rdata0, e_m.data);
        end
      end
      if (ready1) begin
        if (exp_q1.size() == 0) fail_now("ready1_unexpected");
        else begin
          e_m = exp_q1.pop_front();
          if (!e_m.we) check("rdata1", rdata1, e_m.data);
        end
      end
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        gnt_log.push_back(grant);
        if (gnt_q.size() == 0) fail_now("grant_unexpected");
        else begin
          m_w = gnt_q.pop_front();
          check("grant_order", grant, (m_w == 0) ? 2'b01 : 2'b10);
        end
      end
    end
    prev_grant = grant;

    if (rst) begin
      m_owner = -1; m_lock_v = 1'b0; m_lock_p = 0; m_starve = 0; m_last = 1;
      gnt_q.delete(); exp_q0.delete(); exp_q1.delete();
    end else if (m_owner < 0) begin
      if (req0 || req1) begin
        if (m_lock_v && ((m_lock_p == 0) ? req0 : req1)) m_w = m_lock_p;
        else if (req0 && req1) begin
`ifdef ARB_RR_EN
          m_w = 1 - m_last;
`else
          m_w = (m_starve >= STARVE_MAX) ? 0 : 1;
`endif
        end else m_w = req0 ? 0 : 1;
        if (m_w == 0) m_starve = 0;
        else if (req0 && m_starve < STARVE_MAX) m_starve++;
        m_lock_v = 1'b0;
        m_last = m_w;
        m_owner = m_w;
        gnt_q.push_back(m_w);
      end
    end else if (mem_ready) begin
      if ((m_owner == 0) ? we0 : we1) begin
        m_lock_v = 1'b1;
        m_lock_p = m_owner;
      end
      m_owner = -1;
    end else if (!((m_owner == 0) ? req0 : req1)) begin
      m_owner = -1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ex[$];
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    mem_ready = 1'b0; mem_readdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_grant", grant, 2'b00);
    check("reset_ctrl", {mem_req, WriteEnable, ready0, ready1}, 4'b0000);

    // Single read with 3-cycle memory latency.
    seed(32'h100, {16{8'hA5}});
    @(posedge clk); #1;
    fork
      do_txn(0, 1'b0, 32'h100, '0, 1'b0);
      begin
        @(negedge clk); check("single_memreq_n", mem_req, 1'b0);
        @(negedge clk); check("single_memreq_n1", mem_req, 1'b1);
        check("single_addr", memory_address, 32'h100);
        repeat (2) @(negedge clk);
        check("single_early_ready", ready0, 1'b0);
        @(negedge clk);
        check("single_ready0", ready0, 1'b1);
        check("single_rdata0", rdata0, {16{8'hA5}});
        check("single_ready1", ready1, 1'b0);
        @(negedge clk); check("single_idle", grant, 2'b00);
      end
    join

    // Simultaneous requests after reset.
    reset_dut();
    gnt_log.delete();
    fork
      do_txn(0, 1'b0, 32'h200, '0, 1'b0);
      do_txn(1, 1'b0, 32'h1200, '0, 1'b0);
      begin repeat (2) @(negedge clk); check("tie_first", grant, TIE_FIRST); end
    join
    ex.delete(); ex.push_back(TIE_FIRST); ex.push_back(~TIE_FIRST);
    check_log("tie_order", ex);

    // Port-1 write-back then fill stays atomic while port 0 waits.
    reset_dut();
    gnt_log.delete();
    fork
      begin
        do_txn(1, 1'b1, 32'h2000, {4{32'hDEAD_BEEF}}, 1'b1);
        do_txn(1, 1'b0, 32'h3000, '0, 1'b0);
      end
      begin @(posedge clk); #1; do_txn(0, 1'b0, 32'h300, '0, 1'b0); end
    join
    ex.delete(); ex.push_back(2'b10); ex.push_back(2'b10); ex.push_back(2'b01);
    check_log("lock1_order", ex);

    // Port-0 write-back then fill wins over a pending port-1 request.
    reset_dut();
    gnt_log.delete();
    fork
      begin
        do_txn(0, 1'b1, 32'h400, {4{32'h1234_5678}}, 1'b1);
        do_txn(0, 1'b0, 32'h400, '0, 1'b0);
      end
      begin @(posedge clk); #1; do_txn(1, 1'b0, 32'h1400, '0, 1'b0); end
    join
    ex.delete(); ex.push_back(2'b01); ex.push_back(2'b01); ex.push_back(2'b10);
    check_log("lock0_order", ex);

    // Port 0 held against back-to-back port-1 reads.
    reset_dut();
    gnt_log.delete();
    fork
      for (int i = 0; i < 10; i++) do_txn(1, 1'b0, 32'h1000 + 32'(i) * 32'h10, '0, i < 9);
      do_txn(0, 1'b0, 32'h600, '0, 1'b0);
    join
    ex.delete();
`ifdef ARB_RR_EN
    ex.push_back(2'b01);
    for (int i = 0; i < 10; i++) ex.push_back(2'b10);
`else
    for (int i = 0; i < STARVE_MAX; i++) ex.push_back(2'b10);
    ex.push_back(2'b01);
    for (int i = STARVE_MAX; i < 10; i++) ex.push_back(2'b10);
`endif
    check_log("starve_order", ex);

    // Reset in the middle of a port-0 grant.
    reset_dut();
    mem_lat = 12;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h700; wdata0 = '0;
    repeat (2) @(negedge clk);
    check("rstmid_granted", grant, 2'b01);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rstmid_memreq", mem_req, 1'b0);
    check("rstmid_grant", grant, 2'b00);
    check("rstmid_ready0", ready0, 1'b0);
    push_exp(0, 1'b0, 32'h700, '0);
    @(negedge clk);
    check("rstmid_regrant", mem_req, 1'b1);
    wait_ready(0);
    @(posedge clk); #1;
    drop(0);
    mem_lat = 3;

    // Spurious mem_ready while idle.
    @(posedge clk); #3;
    mem_ready = 1'b1;
    mem_readdata = '1;
    @(negedge clk);
    check("spur_ready", {ready0, ready1}, 2'b00);
    check("spur_rdata0", rdata0, 0);
    @(posedge clk); #3;
    mem_ready = 1'b0;
    @(negedge clk);
    check("spur_idle", grant, 2'b00);

    // Randomized traffic on both ports.
    mem_rand = 1'b1;
    @(posedge clk); #1;
    fork
      rand_port(0);
      rand_port(1);
    join
    repeat (5) @(negedge clk);
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);
    check("drain_grants", gnt_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
